// File: rtl/edge_bbox_detect.sv
// edge_bbox_detect: bounding box and pixel count of edge pixels per frame.
// Ports: pixelclk, reset_n (async, active low), i_vsync/i_hsync/i_de/i_rgb
//   video in; o_box_valid (one-cycle report pulse), o_box_found,
//   o_x_min/o_x_max, o_y_min/o_y_max, o_edge_cnt (last frame's result).
module edge_bbox_detect #(
   parameter int         X_W        = 11,
   parameter int         Y_W        = 11,
   parameter logic [7:0] EDGE_LEVEL = 8'h00,
   parameter int         MIN_COUNT  = 1
) (
   input  logic               pixelclk,
   input  logic               reset_n,
   input  logic               i_vsync,
   input  logic               i_hsync,
   input  logic               i_de,
   input  logic [7:0]         i_rgb,
   output logic               o_box_valid,
   output logic               o_box_found,
   output logic [X_W-1:0]     o_x_min,
   output logic [X_W-1:0]     o_x_max,
   output logic [Y_W-1:0]     o_y_min,
   output logic [Y_W-1:0]     o_y_max,
   output logic [X_W+Y_W-1:0] o_edge_cnt
);

   localparam int C_W = X_W + Y_W;
   localparam logic [C_W-1:0] MIN_C = C_W'(MIN_COUNT);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      REPORT
   } state_t;

   state_t         state;
   logic           vsync_d;
   logic           armed;
   logic           de_d;
   logic [X_W-1:0] x_cnt;
   logic [Y_W-1:0] y_cnt;
   logic [X_W-1:0] x_min;
   logic [X_W-1:0] x_max;
   logic [Y_W-1:0] y_min;
   logic [Y_W-1:0] y_max;
   logic [C_W-1:0] edge_cnt;

   logic frame_start;
   logic frame_end;
   logic in_frame;
   logic edge_pix;
   logic found;
   logic unused_hsync;

   assign unused_hsync = i_hsync;

   // armed stays low after reset until vsync is seen low, so a frame
   // already in progress at reset release never starts accumulation.
   assign frame_start = i_vsync & ~vsync_d & armed;
   assign frame_end   = ~i_vsync & vsync_d;

   // The vsync-fall cycle is excluded: its pixel is outside the frame.
   assign in_frame = (state == ACTIVE) & i_vsync;
   assign edge_pix = in_frame & i_de & (i_rgb == EDGE_LEVEL);
   assign found    = (edge_cnt >= MIN_C);

   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         vsync_d     <= 1'b0;
         armed       <= 1'b0;
         de_d        <= 1'b0;
         x_cnt       <= '0;
         y_cnt       <= '0;
         edge_cnt    <= '0;
         x_min       <= '1;
         y_min       <= '1;
         x_max       <= '0;
         y_max       <= '0;
         o_box_valid <= 1'b0;
         o_box_found <= 1'b0;
         o_x_min     <= '0;
         o_x_max     <= '0;
         o_y_min     <= '0;
         o_y_max     <= '0;
         o_edge_cnt  <= '0;
      end else begin
         vsync_d     <= i_vsync;
         o_box_valid <= 1'b0;
         if (!i_vsync) begin
            armed <= 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (frame_start) begin
                  state <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (frame_end) begin
                  state       <= REPORT;
                  o_box_valid <= 1'b1;
                  o_box_found <= found;
                  o_edge_cnt  <= edge_cnt;
                  o_x_min     <= found ? x_min : '0;
                  o_x_max     <= found ? x_max : '0;
                  o_y_min     <= found ? y_min : '0;
                  o_y_max     <= found ? y_max : '0;
               end
            end
            REPORT: begin
               state <= frame_start ? ACTIVE : IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (frame_start) begin
            de_d     <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            edge_cnt <= '0;
            x_min    <= '1;
            y_min    <= '1;
            x_max    <= '0;
            y_max    <= '0;
         end else if (in_frame) begin
            de_d <= i_de;
            if (i_de) begin
               if (!(&x_cnt)) begin
                  x_cnt <= x_cnt + 1'b1;
               end
            end else if (de_d) begin
               // End of a line: next row, column restarts.
               x_cnt <= '0;
               if (!(&y_cnt)) begin
                  y_cnt <= y_cnt + 1'b1;
               end
            end
            if (edge_pix) begin
               if (!(&edge_cnt)) begin
                  edge_cnt <= edge_cnt + 1'b1;
               end
               if (x_cnt < x_min) begin
                  x_min <= x_cnt;
               end
               if (x_cnt > x_max) begin
                  x_max <= x_cnt;
               end
               if (y_cnt < y_min) begin
                  y_min <= y_cnt;
               end
               if (y_cnt > y_max) begin
                  y_max <= y_cnt;
               end
            end
         end
      end
   end

endmodule
